dht11_sensor_emu: RTL
=====================

Name: dht11_sensor_emu

Overview:
Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol, answering a host start pulse with the standard response and 40-bit frame. Used as the bench/loopback model for the team's DHT11 host reader and as a synthesizable stand-in sensor on boards without a physical DHT11. Open-drain on the shared `data` line; frame contents come from registered input bytes.

Parameters:
START_MIN, 18000, minimum host low time (cycles) accepted as a start request
WAKE_DELAY, 30, cycles between detected host release and start of sensor response
RESP_LOW, 80, sensor response low phase (cycles)
RESP_HIGH, 80, sensor response high phase (cycles)
BIT_LOW, 50, low phase preceding each bit and the trailing end-of-frame low (cycles)
BIT0_HIGH, 26, high phase encoding a 0 (cycles)
BIT1_HIGH, 70, high phase encoding a 1 (cycles)
CNT_W, 16, phase counter width; must hold max(START_MIN, all phase lengths)

Ports:
clk  input  1  system clock (defaults assume 1 MHz)
reset_n  input  1  asynchronous, active-low reset
data  inout  1  open-drain DHT11 line: driven 0 or released (z), never driven 1
enable  input  1  1 = respond to start requests
hum_int  input  8  humidity integer byte
hum_dec  input  8  humidity decimal byte
temp_int  input  8  temperature integer byte
temp_dec  input  8  temperature decimal byte
busy  output  1  high from WAKE through END_L inclusive
frame_done  output  1  one-cycle pulse when trailing low completes
short_start  output  1  one-cycle pulse when a host low shorter than START_MIN is rejected

Behaviour:
- Reset (async, reset_n=0): state IDLE, drive_low=0 (line released immediately), busy=0, frame_done=0, short_start=0, counter=0, shift register=0.
- `data` input passes through a 2-flop synchronizer (sync); every decision uses sync. The sync flops reset to 1.
- The line is pulled low iff registered drive_low=1. drive_low is registered and follows state with a uniform one-cycle lag, so each phase appears on the line for exactly its parameter length.
- States:
  - IDLE: when sync=0 and enable=1, go to HOST_LOW with counter=0. A low with enable=0 is ignored.
  - HOST_LOW: counter increments and saturates at all-ones. On sync=1:
    - counter>=START_MIN: go to WAKE.
    - otherwise: pulse short_start and go to IDLE.
  - WAKE: line released. On entry, latch the 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, chk}, with chk = (hum_int+hum_dec+temp_int+temp_dec) mod 256 (8-bit wrap). After WAKE_DELAY cycles go to RESP_L.
  - RESP_L: drive low for RESP_LOW cycles, then RESP_H.
  - RESP_H: released for RESP_HIGH cycles, then BIT_L.
  - BIT_L: drive low for BIT_LOW cycles, then BIT_H.
  - BIT_H: released for BIT1_HIGH cycles if the current bit is 1, BIT0_HIGH if 0. Then shift and increment bit_idx. If bit_idx reaches 40, go to END_L; otherwise go to BIT_L.
  - END_L: drive low for BIT_LOW cycles, then release. Pulse frame_done and go to IDLE.
- Bit order: MSB first, bytes in the listed order (hum_int first, chk last).
- Input bytes changing after WAKE entry do not affect the frame in flight.
- Deasserting enable mid-frame does not abort; the frame completes.
- The line level is not checked while released (no contention detection).
- A new start request is only recognised from IDLE. After frame_done, a host low is accepted from the next cycle.
- Counter resets to 0 on every state change.

Test Plan:
- Frame 0x37,0x00,0x19,0x00:
  - stimulus: host drives low 18000 cycles, then releases
  - required: after 2 sync + 30 cycles, low 80 / high 80, then 40 bits encoding 0x37 00 19 00 50; bit highs measure 26/70 cycles; trailing low 50; frame_done pulses once; busy=0 after.
- Short start: host low for 17999 cycles -> short_start pulses once; line never pulled low by the DUT; busy stays 0.
- Checksum wrap: bytes 0xFF,0xFF,0x01,0x02 -> transmitted chk=0x01.
- Mid-frame changes: change all inputs to 0xAA and drop enable during bit 10 -> the frame still carries the original values and completes. A following start request with enable=0 gets no response.
- Reset mid-frame: assert reset_n=0 during RESP_L -> line goes z the same cycle, busy=0. After release, a new 18000-cycle start yields a full, correct frame.
- Loopback with the team's DHT11 host reader and values 0x28,0x00,0x1E,0x00 -> the reader reports humidity=0x28, temperature=0x1E.

Source files
------------

// File: rtl/dht11_sensor_emu_if.sv
// dht11_sensor_emu_if: control/status bundle between a DHT11 emulator and the
// logic that feeds it measurement bytes.
//
// Signalling: there is no valid/ready pair on this bundle. The host side holds
// enable high to let the emulator answer start requests (sampled only while the
// emulator is idle). The measurement bytes are sampled once per frame, when the
// start request is accepted. The emulator reports busy as a level (response in
// progress), and frame_done / short_start as single-cycle pulses. state_dbg
// mirrors the emulator's FSM state register for observation.
interface dht11_sensor_emu_if;
    logic       enable;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       frame_done;
    logic       short_start;
    logic [2:0] state_dbg;

    modport master (
        output enable, hum_int, hum_dec, temp_int, temp_dec,
        input  busy, frame_done, short_start, state_dbg
    );

    modport slave (
        input  enable, hum_int, hum_dec, temp_int, temp_dec,
        output busy, frame_done, short_start, state_dbg
    );
endinterface

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: responder end of the DHT11 single-wire protocol.
// A qualified host start pulse is answered with the response preamble and a
// 40-bit frame {hum_int, hum_dec, temp_int, temp_dec, chk}, MSB first.
// The shared line is open-drain: pulled low or released, never driven high.
module dht11_sensor_emu #(
    parameter int START_MIN  = 18000,
    parameter int WAKE_DELAY = 30,
    parameter int RESP_LOW   = 80,
    parameter int RESP_HIGH  = 80,
    parameter int BIT_LOW    = 50,
    parameter int BIT0_HIGH  = 26,
    parameter int BIT1_HIGH  = 70,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    inout  wire               data,
    dht11_sensor_emu_if.slave ctrl
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HOST_LOW = 3'd1;
    localparam logic [2:0] S_WAKE     = 3'd2;
    localparam logic [2:0] S_RESP_L   = 3'd3;
    localparam logic [2:0] S_RESP_H   = 3'd4;
    localparam logic [2:0] S_BIT_L    = 3'd5;
    localparam logic [2:0] S_BIT_H    = 3'd6;
    localparam logic [2:0] S_END_L    = 3'd7;

    // The counter starts at 0 on the first cycle of a state, so a phase of
    // length L ends when the counter shows L-1. For the host low, the IDLE
    // cycle that spotted the low is itself a low cycle, so a low of exactly
    // START_MIN cycles is seen in HOST_LOW as a count of START_MIN-1.
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_MIN - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST   = CNT_W'(WAKE_DELAY - 1);
    localparam logic [CNT_W-1:0] RESP_L_LAST = CNT_W'(RESP_LOW - 1);
    localparam logic [CNT_W-1:0] RESP_H_LAST = CNT_W'(RESP_HIGH - 1);
    localparam logic [CNT_W-1:0] BIT_L_LAST  = CNT_W'(BIT_LOW - 1);
    localparam logic [CNT_W-1:0] BIT0_LAST   = CNT_W'(BIT0_HIGH - 1);
    localparam logic [CNT_W-1:0] BIT1_LAST   = CNT_W'(BIT1_HIGH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] bit_h_last;
    logic [39:0]      shreg;
    logic [5:0]       bit_idx;
    logic [7:0]       chk;
    logic             sync_1;
    logic             sync_2;
    logic             drive_low;
    logic             frame_done_r;
    logic             short_start_r;
    logic             do_done;
    logic             do_short;

    // Open-drain output: pull low or release, never drive high.
    assign data = drive_low ? 1'b0 : 1'bz;

    assign chk        = ctrl.hum_int + ctrl.hum_dec + ctrl.temp_int + ctrl.temp_dec;
    assign bit_h_last = shreg[39] ? BIT1_LAST : BIT0_LAST;

    assign ctrl.busy        = (state != S_IDLE) && (state != S_HOST_LOW);
    assign ctrl.frame_done  = frame_done_r;
    assign ctrl.short_start = short_start_r;
    assign ctrl.state_dbg   = state;

    // Two-flop synchronizer for the asynchronous line; idles high like the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= data;
            sync_2 <= sync_1;
        end
    end

    // Next-state decode; the status pulses are decided on the transition.
    always_comb begin
        state_nx = state;
        do_done  = 1'b0;
        do_short = 1'b0;
        case (state)
            S_IDLE: begin
                if (!sync_2 && ctrl.enable) state_nx = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (sync_2) begin
                    if (cnt >= START_LAST) begin
                        state_nx = S_WAKE;
                    end else begin
                        state_nx = S_IDLE;
                        do_short = 1'b1;
                    end
                end
            end
            S_WAKE:   if (cnt == WAKE_LAST)   state_nx = S_RESP_L;
            S_RESP_L: if (cnt == RESP_L_LAST) state_nx = S_RESP_H;
            S_RESP_H: if (cnt == RESP_H_LAST) state_nx = S_BIT_L;
            S_BIT_L:  if (cnt == BIT_L_LAST)  state_nx = S_BIT_H;
            S_BIT_H: begin
                if (cnt == bit_h_last) state_nx = (bit_idx == 6'd39) ? S_END_L : S_BIT_L;
            end
            S_END_L: begin
                if (cnt == BIT_L_LAST) begin
                    state_nx = S_IDLE;
                    do_done  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, phase counter, frame shifter and the registered line driver.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            shreg         <= '0;
            bit_idx       <= '0;
            drive_low     <= 1'b0;
            frame_done_r  <= 1'b0;
            short_start_r <= 1'b0;
        end else begin
            state         <= state_nx;
            frame_done_r  <= do_done;
            short_start_r <= do_short;
            // drive_low trails state by one cycle in every phase, which keeps
            // each phase on the line for exactly its own length.
            drive_low     <= (state == S_RESP_L) || (state == S_BIT_L) || (state == S_END_L);
            if (state_nx != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_HOST_LOW && state_nx == S_WAKE) begin
                shreg   <= {ctrl.hum_int, ctrl.hum_dec, ctrl.temp_int, ctrl.temp_dec, chk};
                bit_idx <= '0;
            end else if (state == S_BIT_H && state_nx != S_BIT_H) begin
                shreg   <= {shreg[38:0], 1'b0};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule
